multi_clk_divider: RTL and testbench

//  NUM_CH-channel programmable clock divider/generator. Each channel has independent high/low

---
 rtl/clk_div_pkg.sv | 15 +
 rtl/clk_div_channel.sv | 136 +++++++++++++
 rtl/multi_clk_divider.sv | 53 +++++
 tb/tb_multi_clk_divider.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/clk_div_pkg.sv
// Shared types and defaults for the multi-channel clock divider.
//   state_t    : per-channel FSM state encoding
//   DEF_CNT_W  : default width of count fields and counters
package clk_div_pkg;

  localparam int unsigned DEF_CNT_W = 32;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_LOW  = 2'd2,
    ST_HIGH = 2'd3
  } state_t;

endpackage

// File: rtl/clk_div_channel.sv
// One programmable divider channel: shadow/active config, phase FSM, counter.
// Ports:
//   clk_i, rst_n             : clock, async active-low reset
//   start_i                  : launch pulse (honoured only when idle and enabled)
//   en_i                     : channel enable; low requests a graceful stop
//   cfg_we_i                 : shadow write strobe for this channel
//   cfg_high_i/low_i/wait_i  : phase lengths and start delay in clk_i cycles
//   clk_o                    : divided clock (flop output)
//   period_o                 : pulse on first cycle of each high phase
//   busy_o                   : channel not idle
module clk_div_channel
  import clk_div_pkg::*;
#(
  parameter int unsigned CNT_W = DEF_CNT_W
) (
  input  logic             clk_i,
  input  logic             rst_n,
  input  logic             start_i,
  input  logic             en_i,
  input  logic             cfg_we_i,
  input  logic [CNT_W-1:0] cfg_high_i,
  input  logic [CNT_W-1:0] cfg_low_i,
  input  logic [CNT_W-1:0] cfg_wait_i,
  output logic             clk_o,
  output logic             period_o,
  output logic             busy_o
);

  // A zero phase length would never terminate the compare, so it runs as one cycle.
  function automatic logic [CNT_W-1:0] sanitise(input logic [CNT_W-1:0] v);
    return (v == '0) ? CNT_W'(1) : v;
  endfunction

  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] r_sh_high, r_sh_low, r_sh_wait;
  logic [CNT_W-1:0] r_act_high, r_act_low, r_act_wait;
  logic             r_clk, r_period, r_busy;

  // Shadow values as seen by a reload in this cycle (same-cycle write bypass).
  logic [CNT_W-1:0] w_sh_high, w_sh_low, w_sh_wait;
  assign w_sh_high = cfg_we_i ? cfg_high_i : r_sh_high;
  assign w_sh_low  = cfg_we_i ? cfg_low_i  : r_sh_low;
  assign w_sh_wait = cfg_we_i ? cfg_wait_i : r_sh_wait;

  // Phase FSM; clk_o/period_o are registered decodes of the state being entered.
  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_IDLE;
      r_cnt      <= '0;
      r_sh_high  <= CNT_W'(1);
      r_sh_low   <= CNT_W'(1);
      r_sh_wait  <= '0;
      r_act_high <= CNT_W'(1);
      r_act_low  <= CNT_W'(1);
      r_act_wait <= '0;
      r_clk      <= 1'b0;
      r_period   <= 1'b0;
      r_busy     <= 1'b0;
    end else begin
      r_period <= 1'b0;
      if (cfg_we_i) begin
        r_sh_high <= cfg_high_i;
        r_sh_low  <= cfg_low_i;
        r_sh_wait <= cfg_wait_i;
      end
      case (r_state)
        ST_IDLE: begin
          r_cnt <= '0;
          r_clk <= 1'b0;
          if (start_i && en_i) begin
            r_act_high <= sanitise(w_sh_high);
            r_act_low  <= sanitise(w_sh_low);
            r_act_wait <= w_sh_wait;
            r_busy     <= 1'b1;
            r_state    <= (w_sh_wait != '0) ? ST_WAIT : ST_LOW;
          end
        end
        ST_WAIT: begin
          if (!en_i) begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
            r_cnt   <= '0;
          end else if (r_cnt == r_act_wait - CNT_W'(1)) begin
            r_state <= ST_LOW;
            r_cnt   <= '0;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        ST_LOW: begin
          if (!en_i) begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
            r_cnt   <= '0;
          end else if (r_cnt == r_act_low - CNT_W'(1)) begin
            r_state  <= ST_HIGH;
            r_cnt    <= '0;
            r_clk    <= 1'b1;
            r_period <= 1'b1;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        ST_HIGH: begin
          // A stop request only takes effect once the high phase is complete.
          if (r_cnt == r_act_high - CNT_W'(1)) begin
            r_cnt <= '0;
            r_clk <= 1'b0;
            if (!en_i) begin
              r_state <= ST_IDLE;
              r_busy  <= 1'b0;
            end else begin
              r_state    <= ST_LOW;
              r_act_high <= sanitise(w_sh_high);
              r_act_low  <= sanitise(w_sh_low);
              r_act_wait <= w_sh_wait;
            end
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
          r_clk   <= 1'b0;
        end
      endcase
    end
  end

  assign clk_o    = r_clk;
  assign period_o = r_period;
  assign busy_o   = r_busy;

endmodule

// File: rtl/multi_clk_divider.sv
// NUM_CH-channel programmable clock divider with common start.
// Ports:
//   clk_i, rst_n      : clock, async active-low reset
//   start_i           : launches every enabled idle channel
//   ch_en_i           : per-channel enable
//   cfg_we_i, cfg_ch_i: config write strobe and target channel
//   cfg_high_i/low_i/wait_i : config payload
//   clk_o, period_o, busy_o : per-channel outputs
module multi_clk_divider
  import clk_div_pkg::*;
#(
  parameter int unsigned NUM_CH = 4,
  parameter int unsigned CNT_W  = DEF_CNT_W,
  localparam int unsigned CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              clk_i,
  input  logic              rst_n,
  input  logic              start_i,
  input  logic [NUM_CH-1:0] ch_en_i,
  input  logic              cfg_we_i,
  input  logic [CH_W-1:0]   cfg_ch_i,
  input  logic [CNT_W-1:0]  cfg_high_i,
  input  logic [CNT_W-1:0]  cfg_low_i,
  input  logic [CNT_W-1:0]  cfg_wait_i,
  output logic [NUM_CH-1:0] clk_o,
  output logic [NUM_CH-1:0] period_o,
  output logic [NUM_CH-1:0] busy_o
);

  logic [NUM_CH-1:0] w_ch_we;

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    // Out-of-range channel indices match no channel, so the write is dropped.
    assign w_ch_we[c] = cfg_we_i && (32'(cfg_ch_i) == 32'(c));

    clk_div_channel #(
      .CNT_W(CNT_W)
    ) u_ch (
      .clk_i      (clk_i),
      .rst_n      (rst_n),
      .start_i    (start_i),
      .en_i       (ch_en_i[c]),
      .cfg_we_i   (w_ch_we[c]),
      .cfg_high_i (cfg_high_i),
      .cfg_low_i  (cfg_low_i),
      .cfg_wait_i (cfg_wait_i),
      .clk_o      (clk_o[c]),
      .period_o   (period_o[c]),
      .busy_o     (busy_o[c])
    );
  end

endmodule

// File: tb/tb_multi_clk_divider.sv
// Directed bench for multi_clk_divider.
module tb_multi_clk_divider;

  localparam int unsigned NUM_CH = 4;
  localparam int unsigned CNT_W  = 32;

  logic              clk_i = 1'b0;
  logic              rst_n;
  logic              start_i;
  logic [NUM_CH-1:0] ch_en_i;
  logic              cfg_we_i;
  logic [1:0]        cfg_ch_i;
  logic [CNT_W-1:0]  cfg_high_i, cfg_low_i, cfg_wait_i;
  logic [NUM_CH-1:0] clk_o, period_o, busy_o;

  int checks = 0;
  int errors = 0;

  multi_clk_divider #(.NUM_CH(NUM_CH), .CNT_W(CNT_W)) dut (
    .clk_i      (clk_i),
    .rst_n      (rst_n),
    .start_i    (start_i),
    .ch_en_i    (ch_en_i),
    .cfg_we_i   (cfg_we_i),
    .cfg_ch_i   (cfg_ch_i),
    .cfg_high_i (cfg_high_i),
    .cfg_low_i  (cfg_low_i),
    .cfg_wait_i (cfg_wait_i),
    .clk_o      (clk_o),
    .period_o   (period_o),
    .busy_o     (busy_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    step();
    step();
    rst_n = 1'b1;
  endtask

  task automatic cfg(input int ch, input int h, input int l, input int w);
    cfg_we_i   = 1'b1;
    cfg_ch_i   = 2'(ch);
    cfg_high_i = CNT_W'(h);
    cfg_low_i  = CNT_W'(l);
    cfg_wait_i = CNT_W'(w);
    step();
    cfg_we_i   = 1'b0;
  endtask

  // Waveform after edge n, with start sampled at edge 0.
  function automatic logic m_clk(input int n, input int w, input int l, input int h);
    if (n < w + l) return 1'b0;
    return ((n - w - l) % (l + h)) < h;
  endfunction

  function automatic logic m_per(input int n, input int w, input int l, input int h);
    if (n < w + l) return 1'b0;
    return ((n - w - l) % (l + h)) == 0;
  endfunction

  int t3_clk[14] = '{0,1,0,1,0,0,1,1,1,1,1,0,0,1};
  int t3_per[14] = '{0,1,0,1,0,0,1,0,0,0,0,0,0,1};

  initial begin
    logic [3:0] e_clk, e_per;
    start_i = 1'b0; ch_en_i = '0; cfg_we_i = 1'b0; cfg_ch_i = '0;
    cfg_high_i = '0; cfg_low_i = '0; cfg_wait_i = '0;

    // Reset state
    do_reset();
    chk("rst_clk", 32'(clk_o), 32'h0);
    chk("rst_per", 32'(period_o), 32'h0);
    chk("rst_busy", 32'(busy_o), 32'h0);

    // 1: ch0 high=2 low=3 wait=0
    cfg(0, 2, 3, 0);
    ch_en_i = 4'b0001; start_i = 1'b1;
    step(); start_i = 1'b0;
    for (int n = 0; n < 14; n++) begin
      chk($sformatf("t1_clk n=%0d", n), 32'(clk_o), 32'(m_clk(n, 0, 3, 2)));
      chk($sformatf("t1_per n=%0d", n), 32'(period_o), 32'(m_per(n, 0, 3, 2)));
      chk($sformatf("t1_busy n=%0d", n), 32'(busy_o), 32'h1);
      step();
    end

    // 2: four channels, wait 0..3, high=low=4, common start
    do_reset();
    for (int c = 0; c < 4; c++) cfg(c, 4, 4, c);
    ch_en_i = 4'b1111; start_i = 1'b1;
    step(); start_i = 1'b0;
    for (int n = 0; n < 30; n++) begin
      for (int c = 0; c < 4; c++) begin
        e_clk[c] = m_clk(n, c, 4, 4);
        e_per[c] = m_per(n, c, 4, 4);
      end
      chk($sformatf("t2_clk n=%0d", n), 32'(clk_o), 32'(e_clk));
      chk($sformatf("t2_per n=%0d", n), 32'(period_o), 32'(e_per));
      step();
    end

    // 3: reconfigure ch1 during LOW; takes effect after the current period
    do_reset();
    cfg(1, 1, 1, 0);
    ch_en_i = 4'b0010; start_i = 1'b1;
    step(); start_i = 1'b0;
    for (int n = 0; n < 14; n++) begin
      chk($sformatf("t3_clk n=%0d", n), 32'(clk_o[1]), 32'(t3_clk[n]));
      chk($sformatf("t3_per n=%0d", n), 32'(period_o[1]), 32'(t3_per[n]));
      if (n == 2) begin
        cfg_we_i = 1'b1; cfg_ch_i = 2'd1;
        cfg_high_i = CNT_W'(5); cfg_low_i = CNT_W'(2); cfg_wait_i = '0;
      end
      if (n == 3) cfg_we_i = 1'b0;
      step();
    end

    // 4: drop enable during a 6-cycle HIGH; it completes, then idles
    do_reset();
    cfg(2, 6, 1, 0);
    ch_en_i = 4'b0100; start_i = 1'b1;
    step(); start_i = 1'b0;
    for (int n = 0; n < 13; n++) begin
      chk($sformatf("t4_clk n=%0d", n), 32'(clk_o), (n >= 1 && n <= 6) ? 32'h4 : 32'h0);
      chk($sformatf("t4_per n=%0d", n), 32'(period_o), (n == 1) ? 32'h4 : 32'h0);
      chk($sformatf("t4_busy n=%0d", n), 32'(busy_o), (n <= 6) ? 32'h4 : 32'h0);
      if (n == 2) ch_en_i = 4'b0000;
      if (n == 9) start_i = 1'b1;
      if (n == 10) start_i = 1'b0;
      step();
    end

    // 5: zero counts act as 1/1; start while busy is ignored
    do_reset();
    cfg(3, 0, 0, 0);
    ch_en_i = 4'b1000; start_i = 1'b1;
    step(); start_i = 1'b0;
    for (int n = 0; n < 12; n++) begin
      chk($sformatf("t5_clk n=%0d", n), 32'(clk_o[3]), 32'(m_clk(n, 0, 1, 1)));
      chk($sformatf("t5_per n=%0d", n), 32'(period_o[3]), 32'(m_per(n, 0, 1, 1)));
      if (n == 4) start_i = 1'b1;
      if (n == 5) start_i = 1'b0;
      step();
    end

    // 6: async reset mid-HIGH, then defaults after reset
    do_reset();
    cfg(0, 4, 1, 0);
    ch_en_i = 4'b0001; start_i = 1'b1;
    step(); start_i = 1'b0;
    step();
    step();
    chk("t6_pre_clk", 32'(clk_o), 32'h1);
    chk("t6_pre_busy", 32'(busy_o), 32'h1);
    #2 rst_n = 1'b0;
    #1;
    chk("t6_rst_clk", 32'(clk_o), 32'h0);
    chk("t6_rst_per", 32'(period_o), 32'h0);
    chk("t6_rst_busy", 32'(busy_o), 32'h0);
    step();
    rst_n = 1'b1;
    start_i = 1'b1;
    step(); start_i = 1'b0;
    for (int n = 0; n < 4; n++) begin
      chk($sformatf("t6_def_clk n=%0d", n), 32'(clk_o), 32'(m_clk(n, 0, 1, 1)));
      step();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
